// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with post-reset clear, registered reads, write bypass and immediate mode
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int IMM_W    = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic              reg_select,
  input  logic              imm_select,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] store_data,
  output logic              busy
);
  localparam logic CLEAR = 1'b0;
  localparam logic READY = 1'b1;
  localparam logic [ADDR_W:0]   NR   = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  logic              state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              rd_ok, rs_ok, wr_en;
  logic [DATA_W-1:0] rd_val, rs_val;
  // bypassed read values, clear sequencing and next-state of every output register
  always_comb begin
    rd_ok        = {1'b0, rd} < NR;
    rs_ok        = {1'b0, rs} < NR;
    wr_en        = state_q == READY && reg_select && rd_ok;
    rd_val       = !rd_ok ? '0 : wr_en ? write_data : mem_q[rd];
    rs_val       = !rs_ok ? '0 : (wr_en && rs == rd) ? write_data : mem_q[rs];
    state_d      = (state_q == CLEAR && ptr_q == LAST) ? READY : state_q;
    ptr_d        = state_q == CLEAR ? ptr_q + 1'b1 : ptr_q;
    busy_d       = state_d == CLEAR;
    rs_data_d    = state_q == READY ? rs_val : rs_data_q;
    rd_data_d    = state_q == READY ? (imm_select ? DATA_W'(imm) : rd_val) : rd_data_q;
    store_data_d = (state_q == READY && imm_select) ? rd_val : store_data_q;
  end
  // control and output registers; reset aborts straight back to the start of the clear sweep
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      busy_q       <= 1'b1;
      rd_data_q    <= '0;
      rs_data_q    <= '0;
      store_data_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      rd_data_q    <= rd_data_d;
      rs_data_q    <= rs_data_d;
      store_data_q <= store_data_d;
    end
  end
  // storage: the clear sweep zeroes one entry per cycle, user writes land only once READY
  always_ff @(posedge CLK) begin
    if (state_q == CLEAR) mem_q[ptr_q] <= '0;
    else if (wr_en) mem_q[rd] <= write_data;
  end
  assign rd_data    = rd_data_q;
  assign rs_data    = rs_data_q;
  assign store_data = store_data_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed table plus random stimulus against a behavioural model, 4-reg and 3-reg instances
module tb_reg_file_param;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] rd = '0, rs = '0;
  logic       reg_select = 1'b0, imm_select = 1'b0;
  logic [2:0] imm = '0;
  logic [7:0] write_data = '0;
  logic [7:0] a_rd [2];
  logic [7:0] a_rs [2];
  logic [7:0] a_st [2];
  logic       a_busy [2];
  int n_tests = 0, n_fail = 0;
  int nr [2] = '{4, 3};
  int clr_left [2];
  logic [7:0] m [2][4];
  logic [7:0] e_rd [2];
  logic [7:0] e_rs [2];
  logic [7:0] e_st [2];
  logic       e_busy [2];
  typedef struct {
    logic [1:0] rd, rs;
    logic       rsel, isel;
    logic [2:0] imm;
    logic [7:0] wd, ers, erd, est;
  } vec_t;
  vec_t tbl [10];

  always #5 CLK = ~CLK;

  reg_file_param u_dut (
    .CLK(CLK), .RST_N(RST_N), .rd(rd), .rs(rs), .reg_select(reg_select), .imm_select(imm_select),
    .imm(imm), .write_data(write_data), .rd_data(a_rd[0]), .rs_data(a_rs[0]), .store_data(a_st[0]), .busy(a_busy[0])
  );
  reg_file_param #(.NUM_REGS(3)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N), .rd(rd), .rs(rs), .reg_select(reg_select), .imm_select(imm_select),
    .imm(imm), .write_data(write_data), .rd_data(a_rd[1]), .rs_data(a_rs[1]), .store_data(a_st[1]), .busy(a_busy[1])
  );

  task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (n=%0d) at %0t: got %h expected %h", name, nr[k], $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check("rd_data", k, a_rd[k], e_rd[k]);
      check("rs_data", k, a_rs[k], e_rs[k]);
      check("store_data", k, a_st[k], e_st[k]);
      check("busy", k, {7'd0, a_busy[k]}, {7'd0, e_busy[k]});
    end
  endtask

  function automatic logic [7:0] mval(input int k, input logic [1:0] a, input logic ready);
    if (int'(a) >= nr[k]) return 8'h00;
    if (ready && reg_select && rd == a) return write_data;
    return m[k][a];
  endfunction

  task automatic model_edge(input int k);
    logic ready;
    ready = clr_left[k] == 0;
    if (ready) begin
      e_rs[k] = mval(k, rs, 1'b1);
      e_rd[k] = imm_select ? {5'd0, imm} : mval(k, rd, 1'b1);
      if (imm_select) e_st[k] = mval(k, rd, 1'b1);
      if (reg_select && int'(rd) < nr[k]) m[k][rd] = write_data;
    end else begin
      clr_left[k]--;
    end
    e_busy[k] = clr_left[k] > 0;
  endtask

  task automatic cyc(input logic [1:0] a_rd_i, input logic [1:0] a_rs_i, input logic s, input logic i,
                     input logic [2:0] im, input logic [7:0] w);
    rd = a_rd_i; rs = a_rs_i; reg_select = s; imm_select = i; imm = im; write_data = w;
    for (int k = 0; k < 2; k++) model_edge(k);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clr_left[k] = nr[k];
      e_rd[k] = '0; e_rs[k] = '0; e_st[k] = '0; e_busy[k] = 1'b1;
      for (int j = 0; j < 4; j++) m[k][j] = '0;
    end
    #1;
    check_all();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    RST_N = 1'b1;
  endtask

  task automatic read_all();
    for (int j = 0; j < 4; j++) cyc(2'(j), 2'(j), 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    tbl[0] = '{2'd2, 2'd0, 1'b1, 1'b0, 3'd0, 8'hA5, 8'h00, 8'hA5, 8'h00};
    tbl[1] = '{2'd0, 2'd2, 1'b0, 1'b0, 3'd0, 8'h00, 8'hA5, 8'h00, 8'h00};
    tbl[2] = '{2'd1, 2'd1, 1'b1, 1'b0, 3'd0, 8'h3C, 8'h3C, 8'h3C, 8'h00};
    tbl[3] = '{2'd1, 2'd1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h3C, 8'h3C, 8'h00};
    tbl[4] = '{2'd3, 2'd0, 1'b1, 1'b0, 3'd0, 8'h77, 8'h00, 8'h77, 8'h00};
    tbl[5] = '{2'd3, 2'd3, 1'b0, 1'b1, 3'd5, 8'h00, 8'h77, 8'h05, 8'h77};
    tbl[6] = '{2'd3, 2'd0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h77, 8'h77};
    tbl[7] = '{2'd2, 2'd2, 1'b1, 1'b1, 3'd7, 8'h5A, 8'h5A, 8'h07, 8'h5A};
    tbl[8] = '{2'd0, 2'd2, 1'b0, 1'b0, 3'd0, 8'h00, 8'h5A, 8'h00, 8'h5A};
    tbl[9] = '{2'd3, 2'd3, 1'b1, 1'b0, 3'd0, 8'h11, 8'h11, 8'h11, 8'h5A};
    reg_select = 1'b1; write_data = 8'hFF;
    @(negedge CLK);
    do_reset();
    for (int j = 0; j < 4; j++) cyc(2'(j), 2'(j), 1'b1, 1'b0, 3'd0, 8'hFF);
    read_all();
    for (int j = 0; j < 10; j++) begin
      cyc(tbl[j].rd, tbl[j].rs, tbl[j].rsel, tbl[j].isel, tbl[j].imm, tbl[j].wd);
      check("tbl_rs_data", 0, a_rs[0], tbl[j].ers);
      check("tbl_rd_data", 0, a_rd[0], tbl[j].erd);
      check("tbl_store_data", 0, a_st[0], tbl[j].est);
    end
    read_all();
    for (int j = 0; j < 400; j++)
      cyc(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)));
    do_reset();
    for (int j = 0; j < 2; j++) cyc(2'(j), 2'(j), 1'b1, 1'b0, 3'd0, 8'hEE);
    do_reset();
    for (int j = 0; j < 4; j++) cyc(2'(j), 2'(3 - j), 1'b1, 1'b1, 3'd6, 8'hC3);
    read_all();
    for (int j = 0; j < 100; j++)
      cyc(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the datapath's 2-entry 8-bit register file.
- Width, depth and immediate width are set by parameters.
- Storage clears itself in hardware after reset, with no memory-file preload.
- Reads are registered with same-cycle write bypass.
- Immediate-substitution mode is kept, feeding the ALU operand path and the store-data path of the CPU datapath.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 4, number of registers; must be ≥2.
- ADDR_W, 2, register address width; must satisfy 2^ADDR_W ≥ NUM_REGS.
- IMM_W, 3, immediate width; must be ≤ DATA_W.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- rd  input  ADDR_W  destination/first-source register address.
- rs  input  ADDR_W  second-source register address.
- reg_select  input  1  write enable; writes write_data to RAM[rd].
- imm_select  input  1  immediate mode for the rd_data output.
- imm  input  IMM_W  immediate operand.
- write_data  input  DATA_W  write data.
- rd_data  output  DATA_W  registered rd read data, or zero-extended imm.
- rs_data  output  DATA_W  registered rs read data.
- store_data  output  DATA_W  registered RAM[rd] value, captured in immediate mode.
- busy  output  1  high while the post-reset clear sequence runs.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=CLEAR, clear pointer=0.
  - rd_data, rs_data, store_data = 0; busy=1.
  - RAM contents undefined until the clear sequence completes.
- State machine:
  - CLEAR: each cycle writes 0 to RAM[ptr] and increments ptr. When ptr=NUM_REGS-1 is written, go to READY next cycle. Clearing takes exactly NUM_REGS cycles after RST_N rises.
  - READY: normal operation; no exit except reset.
- busy:
  - busy=1 in CLEAR and busy=0 in READY, both registered.
  - busy falls on the edge that enters READY.
- During CLEAR:
  - reg_select is ignored; no user write occurs.
  - rd_data, rs_data and store_data hold 0.
- Reads in READY (1-cycle latency):
  - On each edge, rs_data <= value of RAM[rs].
  - If imm_select=0: rd_data <= value of RAM[rd].
  - If imm_select=1: rd_data <= {zeros, imm} (zero-extended to DATA_W) and store_data <= value of RAM[rd].
  - If imm_select=0, store_data holds its previous value.
- Writes in READY:
  - If reg_select=1: RAM[rd] <= write_data on the edge.
  - imm_select does not block writes.
- Write bypass:
  - "Value of RAM[x]" means write_data when reg_select=1 and rd==x in the same cycle, otherwise the stored value.
  - A same-cycle read therefore sees new data, never stale data.
  - Applies to rs_data, to rd_data and to store_data.
- Out-of-range addresses (≥NUM_REGS):
  - Reads return 0.
  - Writes are dropped.
  - No other register is modified.
- Reset mid-operation:
  - RST_N low at any point, including mid-CLEAR, aborts immediately to the reset values.
  - The clear sequence restarts from ptr=0.
- No file I/O and no combinational read paths; all outputs are registered.

Test Plan:
- Reset clear:
  - Stimulus: assert RST_N=0 for 2 cycles, release, hold reg_select=1 with write_data=8'hFF.
  - Required: busy=1 for exactly 4 cycles, then 0; all four registers read 8'h00; the write is ignored during busy.
- Write/read latency:
  - Stimulus: in READY, write 8'hA5 to r2, then next cycle rs=2.
  - Required: rs_data=8'hA5 one edge later.
- Bypass:
  - Stimulus: reg_select=1, rd=1, write_data=8'h3C, rs=1 in the same cycle.
  - Required: rs_data=8'h3C after that edge; a subsequent read of r1 also gives 8'h3C.
- Immediate mode:
  - Stimulus: r3=8'h77; rd=3, imm_select=1, imm=3'b101.
  - Required: rd_data=8'h05 and store_data=8'h77 after the edge; with imm_select=0 next cycle, store_data stays 8'h77 and rd_data=8'h77.
- Out of range:
  - Stimulus: NUM_REGS=3, ADDR_W=2; write 8'h11 to address 3, then read rs=3 and all registers.
  - Required: rs_data=0; r0–r2 unchanged.
- Reset mid-clear:
  - Stimulus: drop RST_N 2 cycles into CLEAR, release.
  - Required: outputs 0 immediately; busy high a full NUM_REGS cycles again.
